// File: rtl/cmos_and2_switch_model_pkg.sv
// rtl/cmos_and2_switch_model_pkg.sv - 4-state encoding, conduction types and switch-level helpers
package cmos_logic_pkg;

    typedef logic [1:0] logic4;

    localparam logic4 L0 = 2'b00;
    localparam logic4 L1 = 2'b01;
    localparam logic4 LZ = 2'b10;
    localparam logic4 LX = 2'b11;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        ON  = 2'd1,
        UNK = 2'd2
    } cond_t;

    function automatic cond_t nmos_cond(logic4 gate);
        case (gate)
            L0:      return OFF;
            L1:      return ON;
            default: return UNK;
        endcase
    endfunction

    function automatic cond_t pmos_cond(logic4 gate);
        case (gate)
            L0:      return ON;
            L1:      return OFF;
            default: return UNK;
        endcase
    endfunction

    function automatic cond_t series_cond(cond_t a, cond_t b);
        if (a == OFF || b == OFF) return OFF;
        if (a == ON && b == ON)   return ON;
        return UNK;
    endfunction

    function automatic cond_t parallel_cond(cond_t a, cond_t b);
        if (a == ON || b == ON)   return ON;
        if (a == OFF && b == OFF) return OFF;
        return UNK;
    endfunction

    // A floating node keeps its charge; a stored node is never Z, so Z degrades to X.
    function automatic logic4 resolve_node(cond_t pull_up, cond_t pull_down, logic4 prev);
        if (pull_up == UNK || pull_down == UNK) return LX;
        if (pull_up == ON && pull_down == OFF)  return L1;
        if (pull_up == OFF && pull_down == ON)  return L0;
        if (pull_up == ON && pull_down == ON)   return LX;
        return (prev == LZ) ? LX : prev;
    endfunction

endpackage

// File: rtl/cmos_and2_switch_model_if.sv
// rtl/cmos_and2_switch_model_if.sv - gate inputs and resolved node outputs of the AND2 cell
interface cmos_and2_switch_model_if;
    import cmos_logic_pkg::*;

    logic4 in1;
    logic4 in2;
    logic4 w3;
    logic4 out2;
    logic  contention;
    logic  float_w3;

    modport master (
        output in1, in2,
        input  w3, out2, contention, float_w3
    );

    modport slave (
        input  in1, in2,
        output w3, out2, contention, float_w3
    );
endinterface

// File: rtl/cmos_and2_switch_model_delay_line.sv
// rtl/cmos_and2_switch_model_delay_line.sv - parameterised-depth 2-bit shift register resetting to X
module switch_delay_line
    import cmos_logic_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic4 d,
    output logic4 q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic4 stages [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= LX;
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cmos_and2_switch_model.sv
// rtl/cmos_and2_switch_model.sv - cycle-based switch-level model of a NAND2 + inverter AND2 cell
module cmos_and2_switch_model
    import cmos_logic_pkg::*;
#(
    parameter int NAND_DLY = 3,
    parameter int INV_DLY  = 2
) (
    input  logic clk,
    input  logic rst,
    cmos_and2_switch_model_if.slave bus
);

    // The node register itself supplies the last cycle of each stage's delay.
    localparam int NAND_DEPTH = (NAND_DLY > 1) ? NAND_DLY - 1 : 0;
    localparam int INV_DEPTH  = (INV_DLY > 1) ? INV_DLY - 1 : 0;

    logic4 in1_d;
    logic4 in2_d;
    logic4 w3_d;
    logic4 w3_q;
    logic4 out2_q;
    logic  contention_q;
    logic  float_q;

    cond_t pu1;
    cond_t pd1;
    cond_t pu2;
    cond_t pd2;
    logic4 w3_next;
    logic4 out2_next;

    switch_delay_line #(.DEPTH(NAND_DEPTH)) u_in1_dly (
        .clk (clk),
        .rst (rst),
        .d   (bus.in1),
        .q   (in1_d)
    );

    switch_delay_line #(.DEPTH(NAND_DEPTH)) u_in2_dly (
        .clk (clk),
        .rst (rst),
        .d   (bus.in2),
        .q   (in2_d)
    );

    switch_delay_line #(.DEPTH(INV_DEPTH)) u_w3_dly (
        .clk (clk),
        .rst (rst),
        .d   (w3_q),
        .q   (w3_d)
    );

    always_comb begin
        pu1       = parallel_cond(pmos_cond(in1_d), pmos_cond(in2_d));
        pd1       = series_cond(nmos_cond(in1_d), nmos_cond(in2_d));
        w3_next   = resolve_node(pu1, pd1, w3_q);
        pu2       = pmos_cond(w3_d);
        pd2       = nmos_cond(w3_d);
        out2_next = resolve_node(pu2, pd2, out2_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w3_q         <= LX;
            out2_q       <= LX;
            contention_q <= 1'b0;
            float_q      <= 1'b0;
        end else begin
            w3_q         <= w3_next;
            out2_q       <= out2_next;
            contention_q <= (pu1 == ON && pd1 == ON) || (pu2 == ON && pd2 == ON);
            float_q      <= (pu1 == OFF && pd1 == OFF);
        end
    end

    assign bus.w3         = w3_q;
    assign bus.out2       = out2_q;
    assign bus.contention = contention_q;
    assign bus.float_w3   = float_q;

endmodule

// File: tb/tb_cmos_and2_switch_model.sv
// tb/tb_cmos_and2_switch_model.sv - randomized and directed checks of the AND2 switch model
module tb_cmos_and2_switch_model;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] in1 = 2'b00;
    logic [1:0] in2 = 2'b00;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cmos_and2_switch_model_if bus_a ();
    cmos_and2_switch_model_if bus_b ();

    assign bus_a.in1 = in1;
    assign bus_a.in2 = in2;
    assign bus_b.in1 = in1;
    assign bus_b.in2 = in2;

    cmos_and2_switch_model #(.NAND_DLY(3), .INV_DLY(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    cmos_and2_switch_model #(.NAND_DLY(1), .INV_DLY(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Input samples taken since the last reset, oldest first: {in1, in2}.
    logic [3:0] hist [$];

    always @(posedge clk or posedge rst) begin
        if (rst) hist.delete();
        else     hist.push_back({in1, in2});
    end

    // Gate-level view of the cell: NAND with 0 dominating, inverter, unknowns give X.
    function automatic logic [1:0] nand_m(logic [1:0] a, logic [1:0] b);
        if (a == 2'b00 || b == 2'b00) return 2'b01;
        if (a == 2'b01 && b == 2'b01) return 2'b00;
        return 2'b11;
    endfunction

    function automatic logic [1:0] inv_m(logic [1:0] a);
        if (a == 2'b00) return 2'b01;
        if (a == 2'b01) return 2'b00;
        return 2'b11;
    endfunction

    function automatic logic [1:0] exp_w3(int nd);
        logic [3:0] s;
        int n = hist.size();
        if (n < nd) return 2'b11;
        s = hist[n-nd];
        return nand_m(s[3:2], s[1:0]);
    endfunction

    function automatic logic [1:0] exp_out2(int nd, int id);
        logic [3:0] s;
        int n = hist.size();
        if (n < nd + id) return 2'b11;
        s = hist[n-nd-id];
        return inv_m(nand_m(s[3:2], s[1:0]));
    endfunction

    task automatic chk(string name, logic [1:0] got, logic [1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_w3",         bus_a.w3,                 exp_w3(3));
        chk("a_out2",       bus_a.out2,               exp_out2(3, 2));
        chk("a_contention", {1'b0, bus_a.contention}, 2'b00);
        chk("a_float_w3",   {1'b0, bus_a.float_w3},   2'b00);
        chk("b_w3",         bus_b.w3,                 exp_w3(1));
        chk("b_out2",       bus_b.out2,               exp_out2(1, 1));
        chk("b_contention", {1'b0, bus_b.contention}, 2'b00);
        chk("b_float_w3",   {1'b0, bus_b.float_w3},   2'b00);
    end

    task automatic step(int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1'b1;
        step(2);
        rst = 1'b0;

        // Reset in the middle of a steady 1/1 stream.
        in1 = 2'b01; in2 = 2'b01;
        step(8);
        chk("pre_rst_out2", bus_a.out2, 2'b01);
        rst = 1'b1;
        #1;
        chk("rst_w3",         bus_a.w3,                 2'b11);
        chk("rst_out2",       bus_a.out2,               2'b11);
        chk("rst_contention", {1'b0, bus_a.contention}, 2'b00);
        step(1);
        rst = 1'b0;
        step(2);
        chk("rel_w3_c2",   bus_a.w3,   2'b11);
        step(1);
        chk("rel_w3_c3",   bus_a.w3,   2'b00);
        step(1);
        chk("rel_out2_c4", bus_a.out2, 2'b11);
        step(1);
        chk("rel_out2_c5", bus_a.out2, 2'b01);

        // Truth table, each combination held six cycles.
        for (int i = 0; i < 4; i++) begin
            in1 = {1'b0, i[1]};
            in2 = {1'b0, i[0]};
            step(5);
            chk("tt_out2", bus_a.out2, (i == 3) ? 2'b01 : 2'b00);
            chk("tt_w3",   bus_a.w3,   (i == 3) ? 2'b00 : 2'b01);
            step(1);
        end

        // Square waves at periods 20 and 40.
        for (int c = 0; c < 80; c++) begin
            in1 = ((c / 10) % 2 == 1) ? 2'b01 : 2'b00;
            in2 = ((c / 20) % 2 == 1) ? 2'b01 : 2'b00;
            step(1);
        end

        // Z on a gate.
        in1 = 2'b10; in2 = 2'b01;
        step(5);
        chk("z1_w3",   bus_a.w3,   2'b11);
        chk("z1_out2", bus_a.out2, 2'b11);
        in1 = 2'b10; in2 = 2'b00;
        step(5);
        chk("z0_w3",   bus_a.w3,   2'b01);
        chk("z0_out2", bus_a.out2, 2'b00);

        // X on a gate, masked then exposed.
        in1 = 2'b11; in2 = 2'b00;
        step(5);
        chk("x0_w3", bus_a.w3, 2'b01);
        in2 = 2'b01;
        step(3);
        chk("x1_w3",        bus_a.w3,   2'b11);
        step(1);
        chk("x1_out2_early", bus_a.out2, 2'b00);
        step(1);
        chk("x1_out2",      bus_a.out2, 2'b11);

        // Minimum delays: out2 rises two cycles after the step.
        in1 = 2'b00; in2 = 2'b00;
        step(4);
        in1 = 2'b01; in2 = 2'b01;
        step(1);
        chk("b_step_c1", bus_b.out2, 2'b00);
        step(1);
        chk("b_step_c2", bus_b.out2, 2'b01);

        // Random values with random hold times and occasional resets.
        for (int r = 0; r < 300; r++) begin
            in1 = 2'($urandom_range(0, 3));
            in2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 4) begin
                rst = 1'b1;
                step(int'($urandom_range(1, 2)));
                rst = 1'b0;
            end
            step(int'($urandom_range(1, 4)));
        end

        step(6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
